// File: rtl/mem_access_if.sv
// EX/MEM bundle in, MEM/WB results and stall out for the memory-access stage.
interface mem_access_if;
  logic         in_valid;
  logic [231:0] in_buf;
  logic         stall;
  logic         out_valid;
  logic [63:0]  data2write;
  logic [4:0]   reg2write;
  logic         reg_write;
  logic [63:0]  branch_address;
  logic         pc_src;

  modport master (
    output in_valid, in_buf,
    input  stall, out_valid, data2write, reg2write, reg_write, branch_address, pc_src
  );

  modport slave (
    input  in_valid, in_buf,
    output stall, out_valid, data2write, reg2write, reg_write, branch_address, pc_src
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: multi-cycle internal data memory, branch resolution,
// and the MEM/WB output register.
module mem_access_stage #(
  parameter int DEPTH       = 256,
  parameter int MEM_LATENCY = 2
) (
  input  logic         clk,
  input  logic         rst,
  mem_access_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MEM_LATENCY + 1);

  // ctl: {RegWrite, MemtoReg, MemWrite, MemRead, BNZ, BZ, B, zero}
  typedef struct packed {
    logic [7:0]  ctl;
    logic [63:0] d2;
    logic [63:0] res;
    logic [63:0] br;
    logic [4:0]  rd;
  } bundle_t;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt_p1, cnt_nxt;
  bundle_t       cur, buf_p1, src;
  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic [63:0]   rd_word, wb;
  logic          accept, emit, do_access, is_mem;
  logic          unused_instr;

  function automatic logic branch_taken(input logic [7:0] c);
    return c[1] | (c[2] & c[0]) | (c[3] & ~c[0]);
  endfunction

  assign cur          = {bus.in_buf[231:32], bus.in_buf[4:0]};
  assign unused_instr = ^bus.in_buf[31:5];
  assign is_mem       = cur.ctl[4] | cur.ctl[5];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt_p1 <= '0;
    end else begin
      state  <= state_nxt;
      cnt_p1 <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_p1;
    accept    = 1'b0;
    emit      = 1'b0;
    do_access = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (bus.in_valid) begin
          accept = 1'b1;
          if (is_mem) begin
            state_nxt = ACCESS;
            cnt_nxt   = CW'(MEM_LATENCY - 1);
          end else begin
            emit = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (cnt_p1 == '0) begin
          do_access = 1'b1;
          emit      = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt_p1 - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.stall = (state == ACCESS);

  // ---- capture stage: bundle held for the duration of a memory access
  always_ff @(posedge clk) begin
    if (accept) buf_p1 <= cur;
  end

  // ALU ops write back straight from the input; memory ops from the held bundle
  assign src     = do_access ? buf_p1 : cur;
  assign idx     = src.res[AW+2:3];
  assign rd_word = mem[idx];
  // A both-MemRead-and-MemWrite op is a plain store, so it never returns the loaded word
  assign wb      = (do_access && src.ctl[6] && !(src.ctl[4] && src.ctl[5])) ? rd_word : src.res;

  always_ff @(posedge clk) begin
    if (do_access && src.ctl[5]) mem[idx] <= src.d2;
  end

  // ---- MEM/WB output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid      <= 1'b0;
      bus.reg_write      <= 1'b0;
      bus.pc_src         <= 1'b0;
      bus.data2write     <= '0;
      bus.reg2write      <= '0;
      bus.branch_address <= '0;
    end else begin
      bus.out_valid <= emit;
      bus.reg_write <= emit & src.ctl[7];
      bus.pc_src    <= emit & branch_taken(src.ctl);
      if (emit) begin
        bus.data2write     <= wb;
        bus.reg2write      <= src.rd;
        bus.branch_address <= src.br;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (DEPTH=256, MEM_LATENCY=2).
module tb_mem_access_stage;
  localparam int ML = 2;
  localparam logic [7:0] RW = 8'h80, M2R = 8'h40, MW = 8'h20, MR = 8'h10,
                         BNZ = 8'h08, BZ = 8'h04, BB = 8'h02, Z = 8'h01;

  logic clk, rst;
  int   n_tests, n_fail;

  mem_access_if bus ();
  mem_access_stage #(.DEPTH(256), .MEM_LATENCY(ML)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [231:0] mk(input logic [4:0] rd, input logic [63:0] br,
                                      input logic [63:0] res, input logic [63:0] d2,
                                      input logic [7:0] ctl);
    return {ctl, d2, res, br, 27'h0, rd};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One isolated load/store: stall for ML cycles, then a single out_valid pulse.
  task automatic mem_op(input string tag, input logic [231:0] b, input logic [63:0] exp,
                        input logic [4:0] exp_rd);
    bus.in_valid = 1'b1;
    bus.in_buf   = b;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < ML; i++) begin
      chk({tag, "_stall"}, bus.stall, 1'b1);
      chk({tag, "_ov_busy"}, bus.out_valid, 1'b0);
      tick();
    end
    chk({tag, "_stall_done"}, bus.stall, 1'b0);
    chk({tag, "_ov"}, bus.out_valid, 1'b1);
    chk({tag, "_data"}, bus.data2write, exp);
    chk({tag, "_rd"}, bus.reg2write, exp_rd);
    tick();
    chk({tag, "_ov_after"}, bus.out_valid, 1'b0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_buf   = '0;
    #1;
    chk("rst_ov", bus.out_valid, 1'b0);
    chk("rst_stall", bus.stall, 1'b0);
    chk("rst_data", bus.data2write, 64'h0);
    chk("rst_ba", bus.branch_address, 64'h0);
    tick();
    tick();
    rst = 1'b0;

    // Pre-store 0x1111 at 0x10, then abandon a store of 0xDEAD there via reset
    mem_op("prestore", mk(5'd7, 64'h0, 64'h10, 64'h1111, MW | RW), 64'h10, 5'd7);
    bus.in_valid = 1'b1;
    bus.in_buf   = mk(5'd7, 64'h0, 64'h10, 64'hDEAD, MW | RW);
    tick();
    bus.in_valid = 1'b0;
    chk("midrst_stall_pre", bus.stall, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_stall", bus.stall, 1'b0);
    chk("midrst_ov", bus.out_valid, 1'b0);
    chk("midrst_data", bus.data2write, 64'h0);
    chk("midrst_rd", bus.reg2write, 64'h0);
    tick();
    tick();
    rst = 1'b0;
    mem_op("ld_after_rst", mk(5'd8, 64'h0, 64'h10, 64'h0, MR | M2R | RW), 64'h1111, 5'd8);

    // ALU ops back to back
    bus.in_valid = 1'b1;
    bus.in_buf = mk(5'd3, 64'h0, 64'd5, 64'h0, RW);
    tick();
    chk("alu5_ov", bus.out_valid, 1'b1);
    chk("alu5_data", bus.data2write, 64'd5);
    chk("alu5_rd", bus.reg2write, 64'd3);
    chk("alu5_rw", bus.reg_write, 1'b1);
    chk("alu5_stall", bus.stall, 1'b0);
    bus.in_buf = mk(5'd3, 64'h0, 64'd6, 64'h0, RW);
    tick();
    chk("alu6_ov", bus.out_valid, 1'b1);
    chk("alu6_data", bus.data2write, 64'd6);
    chk("alu6_stall", bus.stall, 1'b0);
    bus.in_buf = mk(5'd3, 64'h0, 64'd7, 64'h0, RW);
    tick();
    chk("alu7_ov", bus.out_valid, 1'b1);
    chk("alu7_data", bus.data2write, 64'd7);
    chk("alu7_stall", bus.stall, 1'b0);
    bus.in_valid = 1'b0;
    tick();
    chk("alu_idle_ov", bus.out_valid, 1'b0);
    chk("alu_idle_rw", bus.reg_write, 1'b0);
    chk("alu_hold_rd", bus.reg2write, 64'd3);
    chk("alu_hold_data", bus.data2write, 64'd7);

    // Store then load, wrap-around, read-before-write, MemRead+MemWrite
    mem_op("st40", mk(5'd2, 64'h0, 64'h40, 64'h123456789ABCDEF0, MW), 64'h40, 5'd2);
    mem_op("ld40", mk(5'd9, 64'h0, 64'h40, 64'h0, MR | M2R | RW), 64'h123456789ABCDEF0, 5'd9);
    mem_op("st8", mk(5'd2, 64'h0, 64'h8, 64'hAA, MW), 64'h8, 5'd2);
    mem_op("ld808", mk(5'd10, 64'h0, 64'h808, 64'h0, MR | M2R | RW), 64'hAA, 5'd10);
    mem_op("st_rbw", mk(5'd11, 64'h0, 64'h8, 64'hBB, MW | M2R), 64'hAA, 5'd11);
    mem_op("ld_rbw", mk(5'd12, 64'h0, 64'h8, 64'h0, MR | M2R), 64'hBB, 5'd12);
    mem_op("rdwr", mk(5'd13, 64'h0, 64'h8, 64'hCC, MR | MW | M2R), 64'h8, 5'd13);
    mem_op("ld_rdwr", mk(5'd14, 64'h0, 64'h808, 64'h0, MR | M2R), 64'hCC, 5'd14);

    // Branch resolution
    bus.in_valid = 1'b1;
    bus.in_buf = mk(5'd0, 64'h100, 64'h0, 64'h0, BZ | Z);
    tick();
    chk("bz_taken", bus.pc_src, 1'b1);
    chk("bz_addr", bus.branch_address, 64'h100);
    bus.in_buf = mk(5'd0, 64'h180, 64'h0, 64'h0, BZ);
    tick();
    chk("bz_nt", bus.pc_src, 1'b0);
    chk("bz_nt_addr", bus.branch_address, 64'h180);
    bus.in_buf = mk(5'd0, 64'h200, 64'h0, 64'h0, BNZ);
    tick();
    chk("bnz_taken", bus.pc_src, 1'b1);
    bus.in_buf = mk(5'd0, 64'h200, 64'h0, 64'h0, BNZ | Z);
    tick();
    chk("bnz_nt", bus.pc_src, 1'b0);
    bus.in_buf = mk(5'd0, 64'h300, 64'h0, 64'h0, BB);
    tick();
    chk("b_taken", bus.pc_src, 1'b1);
    chk("b_addr", bus.branch_address, 64'h300);
    bus.in_valid = 1'b0;
    tick();
    chk("br_idle_pc", bus.pc_src, 1'b0);
    chk("br_hold_addr", bus.branch_address, 64'h300);

    // Stall holdoff: bundles offered during ACCESS are ignored
    bus.in_valid = 1'b1;
    bus.in_buf = mk(5'd2, 64'h0, 64'h18, 64'h77, MW);
    tick();
    bus.in_buf = mk(5'd1, 64'h0, 64'h999, 64'h0, RW);
    chk("hold_stall1", bus.stall, 1'b1);
    chk("hold_ov1", bus.out_valid, 1'b0);
    tick();
    bus.in_buf = mk(5'd1, 64'h0, 64'h18, 64'h55, MW);
    chk("hold_stall2", bus.stall, 1'b1);
    chk("hold_ov2", bus.out_valid, 1'b0);
    tick();
    bus.in_buf = mk(5'd4, 64'h0, 64'h18, 64'h0, MR | M2R | RW);
    chk("hold_done_stall", bus.stall, 1'b0);
    chk("hold_done_ov", bus.out_valid, 1'b1);
    chk("hold_done_data", bus.data2write, 64'h18);
    chk("hold_done_rd", bus.reg2write, 64'd2);
    tick();
    bus.in_valid = 1'b0;
    chk("hold_ld_stall1", bus.stall, 1'b1);
    chk("hold_ld_ov1", bus.out_valid, 1'b0);
    tick();
    chk("hold_ld_stall2", bus.stall, 1'b1);
    tick();
    chk("hold_ld_ov", bus.out_valid, 1'b1);
    chk("hold_ld_data", bus.data2write, 64'h77);
    chk("hold_ld_rd", bus.reg2write, 64'd4);
    chk("hold_ld_rw", bus.reg_write, 1'b1);
    tick();
    chk("hold_end_ov", bus.out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
